// File: rtl/sequence_checker_pkg.sv
// Shared types and constants for the sequence_checker memory game.
package sequence_checker_pkg;

  localparam int LEVEL_W = 5;
  localparam int RAND_W  = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    FAIL     = 3'd5,
    WIN      = 3'd6
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequence_checker_seq_mem.sv
// Sequence storage: one synchronous write port, one combinational read port, no reset.
module seq_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // write port; every entry is written by ADD before playback reads it
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sequence_checker.sv
// Simon-style sequence memory game. Optional input timeout: define SEQ_TIMEOUT_EN.
module sequence_checker
  import sequence_checker_pkg::*;
#(
  parameter int POS_W          = 2,
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [RAND_W-1:0]  rand_bits,
  input  logic               key_valid,
  input  logic [POS_W-1:0]   key_idx,
  output logic               led_on,
  output logic [POS_W-1:0]   led_idx,
  output logic               busy,
  output logic               wait_key,
  output logic [LEVEL_W-1:0] level,
  output logic               fail,
  output logic               win
);

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_MAX = max_int(max_int(SHOW_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
`else
  localparam int CNT_MAX = max_int(SHOW_CYCLES, GAP_CYCLES);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t             state_r, state_s;
  logic [LEVEL_W-1:0] level_r, level_s;
  logic [IDX_W-1:0]   play_r, play_s;
  logic [IDX_W-1:0]   chk_r, chk_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_step_s;
  logic               we_s;
  logic [IDX_W-1:0]   raddr_s;
  logic [POS_W-1:0]   rdata_s;
  logic [LEVEL_W-1:0] last_s;

`ifdef SEQ_TIMEOUT_EN
  logic unused_s;
  assign unused_s = ^rand_bits[RAND_W-1:POS_W];
`else
  logic unused_s;
  assign unused_s = ^{rand_bits[RAND_W-1:POS_W], TIMEOUT_CYCLES[0]};
`endif

  assign raddr_s = (state_r == WAIT_IN) ? chk_r : play_r;
  assign last_s  = level_r - LEVEL_W'(1);

  seq_mem #(
    .DEPTH (MAX_LEN),
    .WIDTH (POS_W),
    .AW    (IDX_W)
  ) u_seq_mem (
    .clock (clock),
    .we    (we_s),
    .waddr (IDX_W'(last_s)),
    .wdata (rand_bits[POS_W-1:0]),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // state and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      level_r <= {LEVEL_W{1'b0}};
      play_r  <= {IDX_W{1'b0}};
      chk_r   <= {IDX_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      level_r <= level_s;
      play_r  <= play_s;
      chk_r   <= chk_s;
      cnt_r   <= cnt_s;
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_s    = state_r;
    level_s    = level_r;
    play_s     = play_r;
    chk_s      = chk_r;
    cnt_step_s = cnt_r;
    we_s       = 1'b0;
    case (state_r)
      IDLE, FAIL, WIN: begin
        if (start) begin
          level_s = LEVEL_W'(1);
          state_s = ADD;
        end else begin
          state_s = state_r;
        end
      end
      ADD: begin
        we_s    = 1'b1;
        play_s  = {IDX_W{1'b0}};
        state_s = SHOW_ON;
      end
      SHOW_ON: begin
        cnt_step_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(SHOW_CYCLES - 1)) begin
          state_s = SHOW_OFF;
        end else begin
          state_s = SHOW_ON;
        end
      end
      SHOW_OFF: begin
        cnt_step_s = cnt_r + CNT_W'(1);
        if (cnt_r != CNT_W'(GAP_CYCLES - 1)) begin
          state_s = SHOW_OFF;
        end else if (LEVEL_W'(play_r) < last_s) begin
          play_s  = play_r + IDX_W'(1);
          state_s = SHOW_ON;
        end else begin
          chk_s   = {IDX_W{1'b0}};
          state_s = WAIT_IN;
        end
      end
      WAIT_IN: begin
`ifdef SEQ_TIMEOUT_EN
        cnt_step_s = cnt_r + CNT_W'(1);
`endif
        if (key_valid) begin
          if (key_idx != rdata_s) begin
            state_s = FAIL;
          end else if (LEVEL_W'(chk_r) < last_s) begin
            chk_s      = chk_r + IDX_W'(1);
            cnt_step_s = {CNT_W{1'b0}};
          end else if (level_r == LEVEL_W'(MAX_LEN)) begin
            state_s = WIN;
          end else begin
            level_s = level_r + LEVEL_W'(1);
            state_s = ADD;
          end
`ifdef SEQ_TIMEOUT_EN
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_s = FAIL;
`endif
        end else begin
          state_s = WAIT_IN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // every phase starts counting from zero
    cnt_s = (state_s == state_r) ? cnt_step_s : {CNT_W{1'b0}};
  end

  assign led_on   = (state_r == SHOW_ON);
  assign led_idx  = led_on ? rdata_s : {POS_W{1'b0}};
  assign busy     = (state_r != IDLE) && (state_r != FAIL) && (state_r != WIN);
  assign wait_key = (state_r == WAIT_IN);
  assign level    = level_r;
  assign fail     = (state_r == FAIL);
  assign win      = (state_r == WIN);

endmodule

// File: tb/tb_sequence_checker.sv
// Randomized self-checking bench for sequence_checker against a queue-based game model.
module tb_sequence_checker;
  import sequence_checker_pkg::*;

  localparam int POS_W   = 2;
  localparam int MAX_LEN = 16;
  localparam int SHOW    = 8;
  localparam int GAP     = 4;
  localparam int TMO     = 16;

  logic               clock = 1'b0;
  logic               resetn;
  logic               start;
  logic [RAND_W-1:0]  rand_bits;
  logic               key_valid;
  logic [POS_W-1:0]   key_idx;
  logic               led_on;
  logic [POS_W-1:0]   led_idx;
  logic               busy;
  logic               wait_key;
  logic [LEVEL_W-1:0] level;
  logic               fail;
  logic               win;

  int n_total = 0;
  int n_pass  = 0;
  logic [POS_W-1:0] seq_q[$];

  sequence_checker #(
    .POS_W          (POS_W),
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .rand_bits (rand_bits),
    .key_valid (key_valid),
    .key_idx   (key_idx),
    .led_on    (led_on),
    .led_idx   (led_idx),
    .busy      (busy),
    .wait_key  (wait_key),
    .level     (level),
    .fail      (fail),
    .win       (win)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input int exp_level, input bit exp_fail, input bit exp_win);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".wait_key"}, wait_key, 0);
    check_eq({tag, ".led_on"}, led_on, 0);
    check_eq({tag, ".led_idx"}, led_idx, 0);
    check_eq({tag, ".level"}, level, exp_level);
    check_eq({tag, ".fail"}, fail, exp_fail);
    check_eq({tag, ".win"}, win, exp_win);
  endtask

  // Start a game or finish a level; the value on rand_bits becomes the next element.
  task automatic trigger(input bit use_start, input logic [POS_W-1:0] key, input int force_v);
    logic [POS_W-1:0] v;
    v = (force_v >= 0) ? POS_W'(force_v) : POS_W'($urandom_range(0, 3));
    rand_bits = RAND_W'($urandom);
    rand_bits[POS_W-1:0] = v;
    if (use_start) begin
      start     = 1'b1;
      key_valid = 1'($urandom_range(0, 1));
      key_idx   = POS_W'($urandom);
    end else begin
      key_valid = 1'b1;
      key_idx   = key;
      start     = 1'($urandom_range(0, 1));
    end
    tick();
    start     = 1'b0;
    key_valid = 1'b0;
    if (use_start) seq_q.delete();
    seq_q.push_back(v);
    check_eq("add.busy", busy, 1);
    check_eq("add.wait_key", wait_key, 0);
    check_eq("add.led_on", led_on, 0);
    check_eq("add.level", level, seq_q.size());
    check_eq("add.fail", fail, 0);
    check_eq("add.win", win, 0);
  endtask

  // Each element lit for SHOW cycles then dark for GAP; inputs meanwhile are noise.
  task automatic playback();
    for (int i = 0; i < seq_q.size(); i++) begin
      for (int c = 0; c < SHOW + GAP; c++) begin
        if (!(i == 0 && c == 0)) begin
          rand_bits = RAND_W'($urandom);
          key_valid = ($urandom_range(0, 7) == 0);
          key_idx   = POS_W'($urandom);
          start     = ($urandom_range(0, 7) == 0);
        end
        tick();
        check_eq("play.led_on", led_on, (c < SHOW) ? 1 : 0);
        check_eq("play.led_idx", led_idx, (c < SHOW) ? seq_q[i] : 0);
        check_eq("play.busy", busy, 1);
      end
    end
    start     = 1'b0;
    key_valid = 1'b0;
    tick();
    check_eq("wait.wait_key", wait_key, 1);
    check_eq("wait.level", level, seq_q.size());
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(0, 2);
    for (int g = 0; g < n; g++) begin
      tick();
      check_eq("gap.wait_key", wait_key, 1);
    end
  endtask

  // err_level < 0 plays through to a win
  task automatic play_game(input int err_level, input int err_pos, input int first_v);
    int L;
    trigger(1'b1, '0, first_v);
    for (int lvl = 1; lvl <= MAX_LEN; lvl++) begin
      playback();
      L = seq_q.size();
      for (int k = 0; k < L; k++) begin
        idle_gap();
        if (L == err_level && k == err_pos) begin
          key_valid = 1'b1;
          key_idx   = seq_q[k] ^ POS_W'($urandom_range(1, 3));
          tick();
          key_valid = 1'b0;
          check_idle_outputs("wrong", L, 1'b1, 1'b0);
          return;
        end else if (k < L - 1) begin
          key_valid = 1'b1;
          key_idx   = seq_q[k];
          start     = 1'($urandom_range(0, 1));
          tick();
          key_valid = 1'b0;
          start     = 1'b0;
          check_eq("key.wait_key", wait_key, 1);
          check_eq("key.level", level, L);
        end else if (L == MAX_LEN) begin
          key_valid = 1'b1;
          key_idx   = seq_q[k];
          tick();
          key_valid = 1'b0;
          check_idle_outputs("win", MAX_LEN, 1'b0, 1'b1);
          return;
        end else begin
          trigger(1'b0, seq_q[k], -1);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    resetn    = 1'b0;
    start     = 1'b0;
    key_valid = 1'b0;
    key_idx   = '0;
    rand_bits = '0;
    repeat (3) tick();
    check_idle_outputs("reset", 0, 1'b0, 1'b0);
    resetn = 1'b1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check_idle_outputs("idle", 0, 1'b0, 1'b0);

    // first element 2; wrong second key at level 3
    play_game(3, 1, 2);
    key_valid = 1'b1;
    key_idx   = seq_q[0];
    tick();
    key_valid = 1'b0;
    check_idle_outputs("fail_hold", 3, 1'b1, 1'b0);

    // restart from the failed game and play through to a win
    play_game(-1, 0, -1);
    key_valid = 1'b1;
    key_idx   = seq_q[0];
    tick();
    key_valid = 1'b0;
    check_idle_outputs("win_hold", MAX_LEN, 1'b0, 1'b1);

    for (int g = 0; g < 4; g++) begin
      fl = $urandom_range(1, 4);
      play_game(fl, $urandom_range(0, fl - 1), -1);
    end

    // reset in the middle of playback
    trigger(1'b1, '0, -1);
    repeat (3) tick();
    check_eq("pre_rst.led_on", led_on, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_idle_outputs("mid_rst", 0, 1'b0, 1'b0);
    #2;
    resetn = 1'b1;
    tick();
    check_idle_outputs("post_rst", 0, 1'b0, 1'b0);

    // no key in WAIT_IN
    trigger(1'b1, '0, -1);
    playback();
`ifdef SEQ_TIMEOUT_EN
    for (int t = 1; t <= TMO; t++) begin
      tick();
      if (t < TMO) check_eq("tmo.wait_key", wait_key, 1);
    end
    check_idle_outputs("tmo", 1, 1'b1, 1'b0);
`else
    repeat (100) tick();
    check_eq("no_tmo.wait_key", wait_key, 1);
    check_eq("no_tmo.fail", fail, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- POS_W, 2, width of a lamp/key index; 2^POS_W positions
- MAX_LEN, 16, maximum sequence length; reaching it is a win
- SHOW_CYCLES, 8, cycles each sequence element is lit during playback
- GAP_CYCLES, 4, dark cycles after each lit element
- TIMEOUT_CYCLES, 1024, input timeout; used only when SEQ_TIMEOUT_EN is defined
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock  in  1  single system clock; all state changes on its rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a new game
- rand  in  10  free-running random value; bits [POS_W-1:0] are used
- key_valid  in  1  one-cycle pulse; a player key press
- key_idx  in  POS_W  index of the pressed key
- led_on  out  1  a playback lamp is lit
- led_idx  out  POS_W  index of the lit lamp; 0 when led_on=0
- busy  out  1  game running (any state except IDLE, FAIL, WIN)
- wait_key  out  1  block is in WAIT_IN and accepts keys
- level  out  5  current sequence length, 0..MAX_LEN
- fail  out  1  held high in FAIL
- win  out  1  held high in WIN

Function
REQ-003 FSM states SHALL be IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, FAIL, WIN.
REQ-004 IDLE, FAIL or WIN + start: level<=1, go to ADD; start in any other state SHALL be ignored.
REQ-005 ADD SHALL last exactly one cycle: mem[level-1] <= rand[POS_W-1:0]; play index <= 0; next SHOW_ON.
REQ-006 SHOW_ON SHALL last SHOW_CYCLES cycles with led_on=1, led_idx=mem[play index]; then SHOW_OFF.
REQ-007 SHOW_OFF SHALL last GAP_CYCLES cycles with led_on=0; then play index+1 and SHOW_ON if play index < level-1, else check index <= 0 and WAIT_IN.
REQ-008 In WAIT_IN, key_valid with key_idx == mem[check index]: if check index < level-1, check index +1; else if level == MAX_LEN go to WIN, else level+1 and go to ADD.
REQ-009 In WAIT_IN, key_valid with a mismatching key_idx SHALL go to FAIL on the next edge; level SHALL hold its value as the final score.
REQ-010 key_valid outside WAIT_IN SHALL be ignored and SHALL NOT be buffered.
REQ-011 The start/key_valid priority rule in REQ-004/REQ-010 SHALL also apply when both are asserted in the same cycle: start wins in IDLE/FAIL/WIN, key_valid wins in WAIT_IN.
REQ-012 Phase counters SHALL be wide enough for max(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) and SHALL clear on every state entry; no wrap-around inside a phase.
REQ-013 All outputs SHALL be registered or decoded from the registered state only; no combinational path from inputs to outputs.

Reset
REQ-014 resetn=0 SHALL asynchronously force state=IDLE, level=0, all counters 0, led_on=0, led_idx=0, busy=0, wait_key=0, fail=0, win=0, at any time including mid-playback or mid-input.
REQ-015 Sequence memory contents need not be reset; ADD SHALL overwrite every entry before it is read.

Configuration
REQ-016 With SEQ_TIMEOUT_EN defined: TIMEOUT_CYCLES consecutive cycles in WAIT_IN without key_valid SHALL go to FAIL, and the counter SHALL restart on each accepted key.
REQ-017 Without SEQ_TIMEOUT_EN: WAIT_IN SHALL wait indefinitely, the timeout counter SHALL NOT exist, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-018 A shared package SHALL hold the state enum type, the level width constant (5), and the rand width constant (10).
REQ-019 Sequence storage SHALL be a sub-module seq_mem: MAX_LEN x POS_W, one synchronous write port, one combinational read port.

Verification
REQ-020 Reset then start, rand[1:0]=2 -> led_on=1, led_idx=2 for 8 cycles, then 4 dark cycles, then wait_key=1, level=1.
REQ-021 Level 1 stored 2, key_idx=2 -> ADD at level=2; playback shows 2 then the new value; entering the correct two keys -> level=3.
REQ-022 At level 3, second key wrong -> fail=1, busy=0, level stays 3; a later key_valid changes nothing; start -> level=1, fail=0.
REQ-023 MAX_LEN=2, correct keys through level 2 -> win=1, level=2; further keys are ignored.
REQ-024 resetn pulsed low during SHOW_ON -> led_on=0 immediately, state IDLE, level=0.
REQ-025 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no key in WAIT_IN -> fail=1 exactly 16 cycles after wait_key rises; without the macro, wait_key is still 1 after 100 cycles.
